// File: rtl/x_pkg.sv
// Shared definitions for the x_* input-conditioning blocks: debounce state
// encodings, counter width and legal parameter bounds.
package x_pkg;

    localparam int CNT_W           = 8;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN  = 1;
    localparam int FILTER_LEN_MAX  = (1 << CNT_W) - 1;

    // One-hot encoding; any illegal pattern falls back to ST_LOW.
    typedef enum logic [3:0] {
        ST_LOW      = 4'b0001,
        ST_RISE_CHK = 4'b0010,
        ST_HIGH     = 4'b0100,
        ST_FALL_CHK = 4'b1000
    } sm_t;

endpackage

// File: rtl/x_sync_chain.sv
// Parameterized flop-chain synchronizer for a single asynchronous level.
// Synchronous active-low reset clears every stage.
module x_sync_chain
    import x_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("x_sync_chain: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] sync_pipe;

    // Shift the raw level through the chain; the oldest stage is the output.
    always_ff @(posedge clock) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
    end

    assign q = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/x_debounce.sv
// Synchronizer plus glitch filter feeding x_oneshot. q changes only after
// FILTER_LEN consecutive identical synchronized samples; enable=0 bypasses
// the filter. Optional saturating rejected-transition counter under
// X_DEBOUNCE_GLITCH_CNT_EN.
module x_debounce
    import x_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    input  logic enable,
    output logic q,
    output logic busy
`ifdef X_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter
        $error("x_debounce: FILTER_LEN out of range");
    end

    localparam logic [CNT_W-1:0] FL_M1 = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic             ds;
    sm_t              sm, sm_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             q_nxt, busy_nxt;

    x_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d),
        .q       (ds)
    );

    // State, filter count and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sm   <= ST_LOW;
            cnt  <= '0;
            q    <= 1'b0;
            busy <= 1'b0;
        end else begin
            sm   <= sm_nxt;
            cnt  <= cnt_nxt;
            q    <= q_nxt;
            busy <= busy_nxt;
        end
    end

    // Next state: qualify each transition on consecutive matching ds samples.
    always_comb begin
        sm_nxt  = sm;
        cnt_nxt = cnt;
        if (!enable) begin
            // Track ds so re-enabling starts in the matching settled state.
            sm_nxt  = ds ? ST_HIGH : ST_LOW;
            cnt_nxt = '0;
        end else begin
            case (sm)
                ST_LOW: begin
                    if (ds) begin
                        cnt_nxt = ONE;
                        sm_nxt  = (FILTER_LEN == 1) ? ST_HIGH : ST_RISE_CHK;
                    end
                end
                ST_RISE_CHK: begin
                    if (!ds)               sm_nxt  = ST_LOW;
                    else if (cnt == FL_M1) sm_nxt  = ST_HIGH;
                    else                   cnt_nxt = cnt + ONE;
                end
                ST_HIGH: begin
                    if (!ds) begin
                        cnt_nxt = ONE;
                        sm_nxt  = (FILTER_LEN == 1) ? ST_LOW : ST_FALL_CHK;
                    end
                end
                ST_FALL_CHK: begin
                    if (ds)                sm_nxt  = ST_HIGH;
                    else if (cnt == FL_M1) sm_nxt  = ST_LOW;
                    else                   cnt_nxt = cnt + ONE;
                end
                default: begin
                    sm_nxt  = ST_LOW;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs from the state being entered; bypass lands on HIGH/LOW so q follows ds.
    always_comb begin
        q_nxt    = q;
        busy_nxt = (sm_nxt == ST_RISE_CHK) || (sm_nxt == ST_FALL_CHK);
        if (sm_nxt == ST_HIGH)     q_nxt = 1'b1;
        else if (sm_nxt == ST_LOW) q_nxt = 1'b0;
    end

`ifdef X_DEBOUNCE_GLITCH_CNT_EN
    logic glitch_abort;

    assign glitch_abort = enable && (((sm == ST_RISE_CHK) && !ds) ||
                                     ((sm == ST_FALL_CHK) &&  ds));

    // Saturating count of transitions rejected while the filter is active.
    always_ff @(posedge clock) begin
        if (!reset_n)
            glitch_cnt <= '0;
        else if (glitch_abort && (glitch_cnt != {CNT_W{1'b1}}))
            glitch_cnt <= glitch_cnt + ONE;
    end
`endif

endmodule

// File: tb/tb_x_debounce.sv
// Directed bench for x_debounce (defaults SYNC_STAGES=2, FILTER_LEN=4).
// Stimulus pushes the expected post-edge outputs; a monitor pops and checks.
module tb_x_debounce;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       d       = 1'b0;
    logic       enable  = 1'b1;
    logic       q;
    logic       busy;
`ifdef X_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    x_debounce #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d),
        .enable  (enable),
        .q       (q),
        .busy    (busy)
`ifdef X_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int   ph;
        int   e;
        logic q;
        logic busy;
        int   gc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ph     = 0;
    int   edge_no = 0;

    // Drive inputs for the next edge and record what must follow it.
    task automatic step(input logic r, input logic en_i, input logic d_i,
                        input logic eq, input logic eb, input int egc);
        exp_t x;
        @(negedge clock);
        reset_n = r;
        enable  = en_i;
        d       = d_i;
        edge_no++;
        x.ph = ph; x.e = edge_no; x.q = eq; x.busy = eb; x.gc = egc;
        sb.push_back(x);
    endtask

    task automatic phase(input int p);
        ph      = p;
        edge_no = 0;
    endtask

    // Monitor: one expectation per active edge, sampled 1 time unit later.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (q !== x.q) begin
                    errors++;
                    $display("FAIL q ph%0d e%0d: got %b want %b", x.ph, x.e, q, x.q);
                end
                checks++;
                if (busy !== x.busy) begin
                    errors++;
                    $display("FAIL busy ph%0d e%0d: got %b want %b", x.ph, x.e, busy, x.busy);
                end
`ifdef X_DEBOUNCE_GLITCH_CNT_EN
                checks++;
                if (int'(glitch_cnt) != x.gc || $isunknown(glitch_cnt)) begin
                    errors++;
                    $display("FAIL glitch_cnt ph%0d e%0d: got %0d want %0d", x.ph, x.e, glitch_cnt, x.gc);
                end
`endif
            end
        end
    end

    initial begin
        logic dh [0:15];
        int   gc;

        // Reset state.
        phase(0);
        for (int k = 1; k <= 3; k++) step(0, 1, 0, 0, 0, 0);

        // d held high: q rises after edge 6, busy on edges 3..5.
        phase(1);
        for (int k = 1; k <= 8; k++) step(1, 1, 1, k >= 6, k >= 3 && k <= 5, 0);

        // d low for 4 clocks then high: fall after edge 6, re-rise after edge 10.
        phase(2);
        for (int k = 1; k <= 12; k++)
            step(1, 1, k >= 5, (k <= 5) || (k >= 10),
                 (k >= 3 && k <= 5) || (k >= 7 && k <= 9), 0);

        // Settle low.
        phase(3);
        for (int k = 1; k <= 8; k++) step(1, 1, 0, k < 6, k >= 3 && k <= 5, 0);

        // 3-clock pulse is rejected as a glitch.
        phase(4);
        for (int k = 1; k <= 8; k++) step(1, 1, k <= 3, 0, k >= 3 && k <= 5, (k >= 6) ? 1 : 0);

        // Bypass: toggle, then hold 1; q is d delayed by 2 sampled edges.
        phase(5);
        dh[0] = 1'b0;
        dh[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            dh[k+1] = (k <= 10) ? logic'(k % 2) : 1'b1;
            step(1, 0, dh[k+1], dh[k-1], 0, 1);
        end

        // Re-enable with d steady high: nothing moves.
        phase(6);
        for (int k = 1; k <= 6; k++) step(1, 1, 1, 1, 0, 1);

        // Back to low, then reset mid-qualification at cnt=2.
        phase(7);
        for (int k = 1; k <= 8; k++) step(1, 1, 0, k < 6, k >= 3 && k <= 5, 1);
        phase(8);
        for (int k = 1; k <= 4; k++) step(1, 1, 1, 0, k >= 3, 1);
        step(0, 1, 1, 0, 0, 0);

        // Full qualification restarts after reset release.
        phase(9);
        for (int k = 1; k <= 8; k++) step(1, 1, 1, k >= 6, k >= 3 && k <= 5, 0);

        // Settle low again.
        phase(10);
        for (int k = 1; k <= 8; k++) step(1, 1, 0, k < 6, k >= 3 && k <= 5, 0);

        // 300 one-clock pulses: each aborted, counter saturates at 255.
        phase(11);
        for (int k = 1; k <= 604; k++) begin
            gc = (k >= 2) ? (k - 2) / 2 : 0;
            if (gc > 300) gc = 300;
            if (gc > 255) gc = 255;
            step(1, 1, (k <= 600) && (k % 2 == 1), 0,
                 (k >= 3) && (k <= 601) && (k % 2 == 1), gc);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
